fetch_stage: RTL

//  Instruction-fetch stage plus IF/ID pipeline register. It feeds the decode-stage branch/jump resolver

---
 rtl/fetch_stage_if.sv | 13 +
 rtl/fetch_stage.sv | 95 +++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory channel between the fetch stage (master) and imem (slave).
// Variable-latency req/ready handshake: data is valid in the cycle ready is high.
interface fetch_stage_if #(
    parameter int width = 32
);
    logic             imem_req;
    logic [width-1:0] imem_addr;
    logic             imem_ready;
    logic [width-1:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch with IF/ID pipeline register, decode-resolved redirect with
// one-bubble squash, drain of in-flight imem accesses, and saturating BJ counters.
module fetch_stage #(
    parameter int               width    = 32,
    parameter logic [width-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_F,
    input  logic             stall_D,
    input  logic             isBJ_D,
    input  logic             realBJ_D,
    input  logic [width-1:0] targetPC_D,
    fetch_stage_if.master    imem,
    output logic [width-1:0] pc_D,
    output logic [width-1:0] instr_D,
    output logic             valid_D,
    output logic [31:0]      bjCount,
    output logic [31:0]      takenCount
);
    typedef enum logic [1:0] {BOOT, FETCH, DRAIN} state_t;

    state_t           state;
    logic [width-1:0] pc_F;
    logic [width-1:0] redir_pc;
    logic             req;

    logic fetch_done;
    logic redirect;
    logic bj_seen;

    assign fetch_done = req && imem.imem_ready;
    assign redirect   = realBJ_D && valid_D && !stall_D;
    assign bj_seen    = isBJ_D && valid_D && !stall_D;

    // pc_F is left untouched during DRAIN, so it is still the address in flight.
    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_F;

    // NOTE: every register here is written with <= so all branches see the
    // pre-edge values of valid_D, req and state regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= BOOT;
            req        <= 1'b0;
            pc_F       <= RESET_PC;
            redir_pc   <= '0;
            pc_D       <= '0;
            instr_D    <= '0;
            valid_D    <= 1'b0;
            bjCount    <= '0;
            takenCount <= '0;
        end else begin
            req <= 1'b1;
            if (state == BOOT) state <= FETCH;

            if (bj_seen && bjCount != 32'hFFFF_FFFF) bjCount <= bjCount + 32'd1;
            if (redirect && takenCount != 32'hFFFF_FFFF) takenCount <= takenCount + 32'd1;

            if (redirect) begin
                pc_D    <= '0;
                instr_D <= '0;
                valid_D <= 1'b0;
                if (!req || fetch_done) begin
                    pc_F  <= targetPC_D;
                    state <= FETCH;
                end else begin
                    // imem cannot be cancelled: park the target until the ack drains.
                    redir_pc <= targetPC_D;
                    state    <= DRAIN;
                end
            end else if (state == DRAIN && imem.imem_ready) begin
                pc_F  <= redir_pc;
                state <= FETCH;
                if (!stall_D) begin
                    pc_D    <= '0;
                    instr_D <= '0;
                    valid_D <= 1'b0;
                end
            end else if (!stall_D) begin
                if (fetch_done && !stall_F) begin
                    pc_D    <= pc_F;
                    instr_D <= imem.imem_rdata;
                    valid_D <= 1'b1;
                    pc_F    <= pc_F + width'(4);
                end else begin
                    pc_D    <= '0;
                    instr_D <= '0;
                    valid_D <= 1'b0;
                end
            end
            // With stall_D high, a completed fetch is dropped and pc_F re-requests it.
        end
    end
endmodule
